// File: rtl/lut8_cfg_pkg.sv
// lut8_cfg_pkg: shared states, sizes and byte-slot mapping
// for the run-time LUT8 table writer.
package lut8_cfg_pkg;

   localparam int NBYTES = 32;
   localparam int CNT_W  = 5;
   localparam int TBL_W  = 256;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      CHECK,
      COMMIT
   } state_t;

   // LSB-first: byte k lands in slot k; otherwise in slot 31-k.
   function automatic logic [CNT_W-1:0] byte_slot(
      input logic [CNT_W-1:0] idx,
      input bit               lsb_first
   );
      return lsb_first ? idx : ~idx;
   endfunction

endpackage

// File: rtl/lut8_cfg_shadow.sv
// lut8_cfg_shadow: byte-addressed 256-bit staging register.
// nxt_o is the table including any byte written this cycle.
module lut8_cfg_shadow
   import lut8_cfg_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we_i,
   input  logic [CNT_W-1:0] idx_i,
   input  logic [7:0]       din_i,
   output logic [TBL_W-1:0] nxt_o
);

   logic [TBL_W-1:0] tbl_q;
   logic [TBL_W-1:0] tbl_d;
   logic [CNT_W-1:0] slot;

   always_comb begin
      tbl_d = tbl_q;
      slot  = byte_slot(idx_i, LSB_FIRST);
      if (we_i) begin
         tbl_d[{slot, 3'b000} +: 8] = din_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tbl_q <= '0;
      end else begin
         tbl_q <= tbl_d;
      end
   end

   assign nxt_o = tbl_d;

endmodule

// File: rtl/lut8_cfg_writer.sv
// lut8_cfg_writer: streams a 256-bit LUT8 table in, commits it atomically.
// Define LUT8_CFG_WRITER_CHECKSUM_EN to require a trailing XOR checksum byte.
module lut8_cfg_writer
   import lut8_cfg_pkg::*;
#(
   parameter logic [TBL_W-1:0] INIT      = '0,
   parameter bit               LSB_FIRST = 1'b1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       START,
   input  logic [7:0] DIN,
   input  logic       DIN_VLD,
   output logic       DIN_RDY,
   output logic       BUSY,
   output logic       DONE,
   output logic       ERR,
   input  logic [7:0] I,
   output logic       F
);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [TBL_W-1:0] act_q;
   logic [TBL_W-1:0] shd_nxt;
   logic             rdy_q;
   logic             busy_q;
   logic             done_q;
   logic             f_q;
   logic             ld_xfer;
`ifdef LUT8_CFG_WRITER_CHECKSUM_EN
   logic [7:0]       xor_q;
   logic             err_q;
`endif

   assign ld_xfer = (state_q == LOAD) & DIN_VLD & rdy_q;

   lut8_cfg_shadow #(
      .LSB_FIRST(LSB_FIRST)
   ) u_shadow (
      .clk_i(CLK),
      .rst_i(RESET),
      .we_i (ld_xfer),
      .idx_i(cnt_q),
      .din_i(DIN),
      .nxt_o(shd_nxt)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         act_q   <= INIT;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         f_q     <= INIT[0];
`ifdef LUT8_CFG_WRITER_CHECKSUM_EN
         xor_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         f_q    <= act_q[I];
`ifdef LUT8_CFG_WRITER_CHECKSUM_EN
         err_q  <= 1'b0;
`endif
         unique case (state_q)
            IDLE: begin
               if (START) begin
                  state_q <= LOAD;
                  cnt_q   <= '0;
                  rdy_q   <= 1'b1;
                  busy_q  <= 1'b1;
`ifdef LUT8_CFG_WRITER_CHECKSUM_EN
                  xor_q   <= '0;
`endif
               end
            end
            LOAD: begin
               if (ld_xfer) begin
                  cnt_q <= cnt_q + 1'b1;
`ifdef LUT8_CFG_WRITER_CHECKSUM_EN
                  xor_q <= xor_q ^ DIN;
                  if (cnt_q == CNT_W'(NBYTES - 1)) begin
                     state_q <= CHECK;
                  end
`else
                  // Registered outputs: table swaps on entry to COMMIT.
                  if (cnt_q == CNT_W'(NBYTES - 1)) begin
                     state_q <= COMMIT;
                     rdy_q   <= 1'b0;
                     done_q  <= 1'b1;
                     act_q   <= shd_nxt;
                  end
`endif
               end
            end
            CHECK: begin
`ifdef LUT8_CFG_WRITER_CHECKSUM_EN
               if (DIN_VLD & rdy_q) begin
                  rdy_q <= 1'b0;
                  if (DIN == xor_q) begin
                     state_q <= COMMIT;
                     done_q  <= 1'b1;
                     act_q   <= shd_nxt;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     err_q   <= 1'b1;
                  end
               end
`else
               state_q <= IDLE;
`endif
            end
            COMMIT: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign DIN_RDY = rdy_q;
   assign BUSY    = busy_q;
   assign DONE    = done_q;
   assign F       = f_q;
`ifdef LUT8_CFG_WRITER_CHECKSUM_EN
   assign ERR     = err_q;
`else
   assign ERR     = 1'b0;
`endif

endmodule

// File: tb/tb_lut8_cfg_writer.sv
// tb_lut8_cfg_writer: random loads against a byte-list table model,
// with LSB-first and MSB-first instances sharing one stimulus.
module tb_lut8_cfg_writer;

   localparam logic [255:0] INIT_V = {1'b1, 254'd0, 1'b1};

   typedef logic [7:0] bytes_t [32];

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       vld;
   logic [7:0] din;
   logic [7:0] idx;

   logic rdy_l, busy_l, done_l, err_l, f_l;
   logic rdy_m, busy_m, done_m, err_m, f_m;

   logic [255:0] act_l;
   logic [255:0] act_m;

   int n_tot  = 0;
   int n_bad  = 0;
   int n_done = 0;
   int n_err  = 0;

   always #5 clk = ~clk;

   lut8_cfg_writer #(
      .INIT(INIT_V),
      .LSB_FIRST(1'b1)
   ) u_lsb (
      .CLK(clk), .RESET(rst), .START(start),
      .DIN(din), .DIN_VLD(vld), .DIN_RDY(rdy_l),
      .BUSY(busy_l), .DONE(done_l), .ERR(err_l),
      .I(idx), .F(f_l)
   );

   lut8_cfg_writer #(
      .INIT(INIT_V),
      .LSB_FIRST(1'b0)
   ) u_msb (
      .CLK(clk), .RESET(rst), .START(start),
      .DIN(din), .DIN_VLD(vld), .DIN_RDY(rdy_m),
      .BUSY(busy_m), .DONE(done_m), .ERR(err_m),
      .I(idx), .F(f_m)
   );

   always @(posedge clk) begin
      if (done_l) n_done++;
      if (err_l) n_err++;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Table bit b is bit (b mod 8) of the byte that owns slot b/8.
   function automatic logic [255:0] build(input bytes_t b, input bit lsb);
      logic [255:0] t;
      for (int i = 0; i < 256; i++) begin
         t[i] = lsb ? b[i / 8][i % 8] : b[31 - i / 8][i % 8];
      end
      return t;
   endfunction

   task automatic look(input logic [7:0] i);
      idx = i;
      tick();
      chk("f_lsb", f_l, act_l[i]);
      chk("f_msb", f_m, act_m[i]);
   endtask

   task automatic load(input bytes_t b, input bit gappy, input bit poke,
                       input int abort_at, input bit bad_cs,
                       output int xfers);
      logic [255:0] nl;
      logic [255:0] nm;
      int  cyc;
      int  d0;
      int  e0;
      bit  ok;
`ifdef LUT8_CFG_WRITER_CHECKSUM_EN
      logic [7:0] x;
      x = 8'h00;
      for (int k = 0; k < 32; k++) x ^= b[k];
`endif
      nl = build(b, 1'b1);
      nm = build(b, 1'b0);
      d0 = n_done;
      e0 = n_err;
      ok = !bad_cs;
      start = 1'b1;
      vld   = 1'b1;
      din   = 8'hFF;
      tick();
      start = 1'b0;
      vld   = 1'b0;
      chk("busy_on", busy_l, 1);
      chk("rdy_on", rdy_l, 1);
      xfers = 0;
      cyc   = 0;
      while (xfers < 32 && xfers != abort_at && cyc < 2000) begin
         vld   = gappy ? (cyc % 2 == 1) : 1'b1;
         start = poke && (cyc == 7 || cyc == 20);
         din   = b[xfers];
         idx   = 8'($urandom);
         if (vld && rdy_l) xfers++;
         tick();
         chk("f_load_l", f_l, act_l[idx]);
         chk("f_load_m", f_m, act_m[idx]);
         cyc++;
      end
      start = 1'b0;
      vld   = 1'b0;
      if (cyc >= 2000) chk("load_timeout", 0, 1);
      if (xfers == abort_at) return;
`ifdef LUT8_CFG_WRITER_CHECKSUM_EN
      chk("rdy_check", rdy_l, 1);
      chk("done_check", done_l, 0);
      vld = 1'b1;
      din = x ^ {7'd0, bad_cs};
      tick();
      vld = 1'b0;
`endif
      if (ok) begin
         chk("done_pulse_l", done_l, 1);
         chk("done_pulse_m", done_m, 1);
         chk("busy_commit", busy_l, 1);
         chk("rdy_commit", rdy_l, 0);
         chk("err_commit", err_l, 0);
         idx = 8'($urandom);
         tick();
         act_l = nl;
         act_m = nm;
         chk("f_new_l", f_l, act_l[idx]);
         chk("f_new_m", f_m, act_m[idx]);
         chk("done_low", done_l, 0);
         chk("busy_off", busy_l, 0);
         chk("done_cnt", n_done - d0, 1);
      end else begin
         chk("err_pulse", err_l, 1);
         chk("done_err", done_l, 0);
         chk("busy_err", busy_l, 0);
         tick();
         chk("err_low", err_l, 0);
         chk("err_cnt", n_err - e0, 1);
         chk("done_cnt_err", n_done - d0, 0);
      end
   endtask

   bytes_t bb;
   int     nx;

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      vld   = 1'b0;
      din   = 8'h00;
      idx   = 8'h00;
      act_l = INIT_V;
      act_m = INIT_V;
      tick();
      tick();
      chk("rst_rdy", rdy_l, 0);
      chk("rst_busy", busy_l, 0);
      chk("rst_done", done_l, 0);
      chk("rst_err", err_l, 0);
      chk("rst_f", f_l, 1);
      rst = 1'b0;
      look(8'h00);
      chk("init_f00", f_l, 1);
      look(8'hFF);
      chk("init_fff", f_l, 1);
      look(8'h01);
      chk("init_f01", f_l, 0);

      // All-0xAA table: F equals I[0].
      for (int k = 0; k < 32; k++) bb[k] = 8'hAA;
      load(bb, 1'b0, 1'b0, 99, 1'b0, nx);
      look(8'h01);
      chk("aa_f01", f_l, 1);
      look(8'h02);
      chk("aa_f02", f_l, 0);

      for (int k = 0; k < 32; k++) bb[k] = 8'($urandom);
      load(bb, 1'b1, 1'b0, 99, 1'b0, nx);
      for (int k = 0; k < 8; k++) look(8'($urandom));

      for (int k = 0; k < 32; k++) bb[k] = 8'hAA;
      load(bb, 1'b1, 1'b1, 99, 1'b0, nx);
      chk("xfers_gappy", nx, 32);
      look(8'h01);
      chk("aa2_f01", f_l, 1);
      look(8'h02);
      chk("aa2_f02", f_l, 0);

      // Only byte 0 = 0x80: MSB-first sets index 255, LSB-first index 7.
      for (int k = 0; k < 32; k++) bb[k] = 8'h00;
      bb[0] = 8'h80;
      load(bb, 1'b0, 1'b0, 99, 1'b0, nx);
      look(8'hFF);
      chk("msb_fff", f_m, 1);
      look(8'h07);
      chk("msb_f07", f_m, 0);
      chk("lsb_f07", f_l, 1);

      for (int k = 0; k < 32; k++) bb[k] = 8'($urandom);
      load(bb, 1'b1, 1'b0, 10, 1'b0, nx);
      chk("xfers_abort", nx, 10);
      rst = 1'b1;
      #2;
      chk("abort_busy", busy_l, 0);
      chk("abort_rdy", rdy_l, 0);
      chk("abort_f", f_l, 1);
      tick();
      rst   = 1'b0;
      act_l = INIT_V;
      act_m = INIT_V;
      look(8'h00);
      look(8'hFF);
      look(8'h80);
      load(bb, 1'b0, 1'b0, 99, 1'b0, nx);
      for (int k = 0; k < 10; k++) look(8'($urandom));

`ifdef LUT8_CFG_WRITER_CHECKSUM_EN
      for (int k = 0; k < 32; k++) bb[k] = 8'h5A;
      load(bb, 1'b0, 1'b0, 99, 1'b0, nx);
      look(8'h01);
      chk("cs_f01", f_l, 1);
      load(bb, 1'b0, 1'b0, 99, 1'b1, nx);
      look(8'h01);
      for (int k = 0; k < 32; k++) bb[k] = 8'($urandom);
      load(bb, 1'b1, 1'b0, 99, 1'b1, nx);
      for (int k = 0; k < 10; k++) look(8'($urandom));
`endif

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
